conv_window_addr_gen: RTL and testbench

Parametrised sliding-window address generator for the convolution image RAM; successor to the fixed 5x5/3x3 address counter.
- Walks every filter tap of every output position across all input channels, with no external mode-select input.
- Owns its loop state machine and has a start/done handshake plus a valid/ready address stream.
- Sits between the conv controller and the image RAM read port, alongside the PE array.

---
 rtl/conv_addr_pkg.sv | 34 +++
 rtl/conv_window_addr_gen_if.sv | 36 +++
 rtl/conv_tap_counter.sv | 31 +++
 rtl/pipe_reg.sv | 22 ++
 rtl/conv_window_addr_gen.sv | 137 +++++++++++++
 tb/tb_conv_window_addr_gen.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/conv_addr_pkg.sv
// Shared types, default geometry and elaboration helpers for the conv address generators.
package conv_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } conv_state_e;

    localparam int DEF_IFMAP_W  = 5;
    localparam int DEF_IFMAP_H  = 5;
    localparam int DEF_FILTER_W = 3;
    localparam int DEF_STRIDE   = 1;
    localparam int DEF_CHANNELS = 1;
    localparam int DEF_ADDR_W   = 5;

    function automatic int out_dim(input int ifmap, input int filter, input int stride);
        return (ifmap - filter) / stride + 1;
    endfunction

    // Bits needed to hold n distinct values; never below 1 so vectors stay legal.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w = w + 1;
        if (w < 1) w = 1;
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// Control and address-stream bundle between the conv controller, the generator and the image RAM.
// WEIGHT_RAM_ADDR exists only when CONV_ADDR_WEIGHT_EN is defined.
interface conv_window_addr_gen_if #(
    parameter int ADDR_W  = 5,
    parameter int WADDR_W = 4
);
    logic              START;
    logic              ADDR_READY;
    logic [ADDR_W-1:0] IMAGE_RAM_ADDR;
    logic              ADDR_VALID;
    logic              WIN_LAST;
    logic              FRAME_LAST;
    logic              BUSY;
    logic              DONE;
`ifdef CONV_ADDR_WEIGHT_EN
    logic [WADDR_W-1:0] WEIGHT_RAM_ADDR;

    modport master (
        input  START, ADDR_READY,
        output IMAGE_RAM_ADDR, ADDR_VALID, WIN_LAST, FRAME_LAST, BUSY, DONE, WEIGHT_RAM_ADDR
    );
    modport slave (
        output START, ADDR_READY,
        input  IMAGE_RAM_ADDR, ADDR_VALID, WIN_LAST, FRAME_LAST, BUSY, DONE, WEIGHT_RAM_ADDR
    );
`else
    modport master (
        input  START, ADDR_READY,
        output IMAGE_RAM_ADDR, ADDR_VALID, WIN_LAST, FRAME_LAST, BUSY, DONE
    );
    modport slave (
        output START, ADDR_READY,
        input  IMAGE_RAM_ADDR, ADDR_VALID, WIN_LAST, FRAME_LAST, BUSY, DONE
    );
`endif
endinterface

// File: rtl/conv_tap_counter.sv
// One loop level of the window walk: counts 0..LIMIT, wraps to 0 and carries out on the wrap.
module conv_tap_counter
    import conv_addr_pkg::*;
#(
    parameter int LIMIT = 2,
    parameter int W     = clog2_min1(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last,
    output logic         carry
);
    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign last       = (count_reg == W'(LIMIT));
    assign carry      = en & last;
    assign count_next = last ? '0 : count_reg + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_reg.sv
// Enabled pipeline register with asynchronous active-low clear.
module PipeReg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/conv_window_addr_gen.sv
// Sliding-window image RAM address generator (loop order oy, ox, c, ky, kx) built from running bases.
// Optional weight RAM address output enabled by defining CONV_ADDR_WEIGHT_EN.
module conv_window_addr_gen
    import conv_addr_pkg::*;
#(
    parameter int IFMAP_W  = DEF_IFMAP_W,
    parameter int IFMAP_H  = DEF_IFMAP_H,
    parameter int FILTER_W = DEF_FILTER_W,
    parameter int STRIDE   = DEF_STRIDE,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    conv_window_addr_gen_if.master bus
);
    localparam int OUT_W     = out_dim(IFMAP_W, FILTER_W, STRIDE);
    localparam int OUT_H     = out_dim(IFMAP_H, FILTER_W, STRIDE);
    localparam int NUM_LVL   = 5;
    localparam int LIMITS [NUM_LVL] = '{FILTER_W - 1, FILTER_W - 1, CHANNELS - 1, OUT_W - 1, OUT_H - 1};
    localparam int MAX_LIMIT = max2(max2(FILTER_W - 1, CHANNELS - 1), max2(OUT_W - 1, OUT_H - 1));
    localparam int CNT_W     = clog2_min1(MAX_LIMIT + 1);

    localparam logic [ADDR_W-1:0] ROW_INC   = ADDR_W'(IFMAP_W);
    localparam logic [ADDR_W-1:0] PLANE_INC = ADDR_W'(IFMAP_W * IFMAP_H);
    localparam logic [ADDR_W-1:0] X_INC     = ADDR_W'(STRIDE);
    // Stepping from the last window of a row to the first of the next: down one stride, back across.
    localparam logic [ADDR_W-1:0] Y_INC     = ADDR_W'(STRIDE * IFMAP_W - (OUT_W - 1) * STRIDE);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_FIN  = FIN;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       run;
    logic       hs;

    // Level index: 0=kx, 1=ky, 2=c, 3=ox, 4=oy.
    logic [NUM_LVL-1:0] lvl_en;
    logic [NUM_LVL-1:0] lvl_last;
    logic [NUM_LVL-1:0] lvl_carry;
    logic [CNT_W-1:0]   lvl_cnt [NUM_LVL];

    logic [ADDR_W-1:0] row_base_reg,  row_base_next;
    logic [ADDR_W-1:0] chan_base_reg, chan_base_next;
    logic [ADDR_W-1:0] win_base_reg,  win_base_next;
    logic              win_last;

    assign run = (state_reg == ST_RUN);
    assign hs  = run & bus.ADDR_READY;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LVL; gi++) begin : g_lvl
            if (gi == 0) begin : g_head
                assign lvl_en[gi] = hs;
            end else begin : g_chain
                assign lvl_en[gi] = lvl_carry[gi-1];
            end
            conv_tap_counter #(
                .LIMIT (LIMITS[gi]),
                .W     (CNT_W)
            ) u_cnt (
                .clk   (CLK),
                .rst_n (RST),
                .en    (lvl_en[gi]),
                .count (lvl_cnt[gi]),
                .last  (lvl_last[gi]),
                .carry (lvl_carry[gi])
            );
        end
    endgenerate

    // Only kx is needed as a value; the outer levels are tracked by the bases.
    logic unused_cnt;
    assign unused_cnt = ^{lvl_cnt[1], lvl_cnt[2], lvl_cnt[3], lvl_cnt[4]};

    assign row_base_next  = lvl_last[1] ? '0 : row_base_reg + ROW_INC;
    assign chan_base_next = lvl_last[2] ? '0 : chan_base_reg + PLANE_INC;
    assign win_base_next  = (lvl_last[3] & lvl_last[4]) ? '0 :
                            lvl_last[3]                 ? win_base_reg + Y_INC :
                                                          win_base_reg + X_INC;

    PipeReg #(.W(ADDR_W)) u_row_base (
        .clk(CLK), .rst_n(RST), .en(lvl_carry[0]), .d(row_base_next), .q(row_base_reg)
    );
    PipeReg #(.W(ADDR_W)) u_chan_base (
        .clk(CLK), .rst_n(RST), .en(lvl_carry[1]), .d(chan_base_next), .q(chan_base_reg)
    );
    PipeReg #(.W(ADDR_W)) u_win_base (
        .clk(CLK), .rst_n(RST), .en(lvl_carry[2]), .d(win_base_next), .q(win_base_reg)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.START) state_next = ST_RUN;
            ST_RUN:  if (lvl_carry[4]) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign win_last           = run & lvl_last[0] & lvl_last[1] & lvl_last[2];
    assign bus.IMAGE_RAM_ADDR = run ? (win_base_reg + chan_base_reg + row_base_reg + ADDR_W'(lvl_cnt[0])) : '0;
    assign bus.ADDR_VALID     = run;
    assign bus.WIN_LAST       = win_last;
    assign bus.FRAME_LAST     = win_last & lvl_last[3] & lvl_last[4];
    assign bus.BUSY           = (state_reg != ST_IDLE);
    assign bus.DONE           = (state_reg == ST_FIN);

`ifdef CONV_ADDR_WEIGHT_EN
    localparam int WADDR_W = clog2_min1(CHANNELS * FILTER_W * FILTER_W);

    logic [WADDR_W-1:0] waddr_reg;
    logic [WADDR_W-1:0] waddr_next;

    // Taps within a window are visited in weight-memory order, so a plain counter suffices.
    assign waddr_next = lvl_carry[2] ? '0 : waddr_reg + WADDR_W'(1);

    PipeReg #(.W(WADDR_W)) u_waddr (
        .clk(CLK), .rst_n(RST), .en(hs), .d(waddr_next), .q(waddr_reg)
    );

    assign bus.WEIGHT_RAM_ADDR = waddr_reg;
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: default, stride-2 and two-channel geometries.
// Weight address checks are active when CONV_ADDR_WEIGHT_EN is defined.
module tb_conv_window_addr_gen;

    logic clk;
    logic rst_n;
    logic start_v [3];
    logic ready_v [3];
    int   sel;
    int   checks;
    int   failures;

    logic [5:0] obs_addr;
    logic       obs_valid, obs_wl, obs_fl, obs_busy, obs_done;
    logic [4:0] obs_waddr;

    conv_window_addr_gen_if #(.ADDR_W(5), .WADDR_W(4)) if0 ();
    conv_window_addr_gen_if #(.ADDR_W(5), .WADDR_W(4)) if1 ();
    conv_window_addr_gen_if #(.ADDR_W(6), .WADDR_W(5)) if2 ();

    assign if0.START = start_v[0];  assign if0.ADDR_READY = ready_v[0];
    assign if1.START = start_v[1];  assign if1.ADDR_READY = ready_v[1];
    assign if2.START = start_v[2];  assign if2.ADDR_READY = ready_v[2];

    conv_window_addr_gen u_dut0 (.CLK(clk), .RST(rst_n), .bus(if0));

    conv_window_addr_gen #(
        .IFMAP_W(5), .IFMAP_H(5), .FILTER_W(3), .STRIDE(2), .CHANNELS(1), .ADDR_W(5)
    ) u_dut1 (.CLK(clk), .RST(rst_n), .bus(if1));

    conv_window_addr_gen #(
        .IFMAP_W(5), .IFMAP_H(5), .FILTER_W(3), .STRIDE(1), .CHANNELS(2), .ADDR_W(6)
    ) u_dut2 (.CLK(clk), .RST(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_addr  = '0;
        obs_valid = 1'b0;
        obs_wl    = 1'b0;
        obs_fl    = 1'b0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        obs_waddr = '0;
        case (sel)
            0: begin
                obs_addr = {1'b0, if0.IMAGE_RAM_ADDR}; obs_valid = if0.ADDR_VALID; obs_wl = if0.WIN_LAST;
                obs_fl = if0.FRAME_LAST; obs_busy = if0.BUSY; obs_done = if0.DONE;
`ifdef CONV_ADDR_WEIGHT_EN
                obs_waddr = {1'b0, if0.WEIGHT_RAM_ADDR};
`endif
            end
            1: begin
                obs_addr = {1'b0, if1.IMAGE_RAM_ADDR}; obs_valid = if1.ADDR_VALID; obs_wl = if1.WIN_LAST;
                obs_fl = if1.FRAME_LAST; obs_busy = if1.BUSY; obs_done = if1.DONE;
`ifdef CONV_ADDR_WEIGHT_EN
                obs_waddr = {1'b0, if1.WEIGHT_RAM_ADDR};
`endif
            end
            default: begin
                obs_addr = if2.IMAGE_RAM_ADDR; obs_valid = if2.ADDR_VALID; obs_wl = if2.WIN_LAST;
                obs_fl = if2.FRAME_LAST; obs_busy = if2.BUSY; obs_done = if2.DONE;
`ifdef CONV_ADDR_WEIGHT_EN
                obs_waddr = if2.WEIGHT_RAM_ADDR;
`endif
            end
        endcase
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s sel=%0d got=%0d exp=%0d", tag, sel, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_addr"},  int'(obs_addr),  0);
        check_val({tag, "_valid"}, int'(obs_valid), 0);
        check_val({tag, "_wlast"}, int'(obs_wl),    0);
        check_val({tag, "_flast"}, int'(obs_fl),    0);
        check_val({tag, "_busy"},  int'(obs_busy),  0);
        check_val({tag, "_done"},  int'(obs_done),  0);
    endtask

    // Walks the reference loop nest; optional stall, START pulse in RUN, and mid-frame reset at a tap index.
    task automatic run_frame(input int s, input int iw, input int ih, input int fw, input int st, input int ch,
                             input int stall_at, input int pulse_at, input int rst_at);
        int ow, oh, n, exp_addr, exp_w;
        bit aborted;
        bit exp_wl, exp_fl;
        sel = s;
        ow = (iw - fw) / st + 1;
        oh = (ih - fw) / st + 1;
        n = 0;
        aborted = 1'b0;
        start_v[s] = 1'b1;
        step();
        start_v[s] = 1'b0;
        check_val("valid_after_start", int'(obs_valid), 1);
        for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < ch; c++)
        for (int ky = 0; ky < fw; ky++)
        for (int kx = 0; kx < fw; kx++) begin
            if (!aborted) begin
                exp_addr = c * iw * ih + (oy * st + ky) * iw + ox * st + kx;
                exp_w    = c * fw * fw + ky * fw + kx;
                exp_wl   = (c == ch - 1) && (ky == fw - 1) && (kx == fw - 1);
                exp_fl   = exp_wl && (ox == ow - 1) && (oy == oh - 1);
                if (n == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle_outputs("mid_reset");
                    $display("txn sel=%0d n=%0d reset asserted", s, n);
                    step();
                    rst_n = 1'b1;
                    step();
                    check_idle_outputs("after_reset");
                    aborted = 1'b1;
                end else begin
                    check_val("addr",  int'(obs_addr),  exp_addr);
                    check_val("valid", int'(obs_valid), 1);
                    check_val("wlast", int'(obs_wl),    int'(exp_wl));
                    check_val("flast", int'(obs_fl),    int'(exp_fl));
                    check_val("busy",  int'(obs_busy),  1);
`ifdef CONV_ADDR_WEIGHT_EN
                    check_val("waddr", int'(obs_waddr), exp_w);
`endif
                    $display("txn sel=%0d n=%0d addr=%0d wlast=%0b flast=%0b", s, n, obs_addr, obs_wl, obs_fl);
                    if (n == stall_at) begin
                        ready_v[s] = 1'b0;
                        repeat (4) begin
                            step();
                            check_val("stall_addr",  int'(obs_addr),  exp_addr);
                            check_val("stall_valid", int'(obs_valid), 1);
                            check_val("stall_wlast", int'(obs_wl),    int'(exp_wl));
                            check_val("stall_flast", int'(obs_fl),    int'(exp_fl));
                        end
                        ready_v[s] = 1'b1;
                    end
                    if (n == pulse_at) start_v[s] = 1'b1;
                    step();
                    start_v[s] = 1'b0;
                    n++;
                end
            end
        end
        if (!aborted) begin
            check_val("fin_done",  int'(obs_done),  1);
            check_val("fin_valid", int'(obs_valid), 0);
            check_val("fin_busy",  int'(obs_busy),  1);
            step();
            check_val("idle_done", int'(obs_done),  0);
            check_val("idle_busy", int'(obs_busy),  0);
            $display("txn sel=%0d frame complete handshakes=%0d", s, n);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b1;
        end
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_idle_outputs("reset");
        end
        rst_n = 1'b1;
        step();

        // Default geometry with a 4-cycle stall at address 6 and a START pulse mid-frame.
        run_frame(0, 5, 5, 3, 1, 1, 4, 20, -1);
        step();
        check_val("stays_idle", int'(obs_busy), 0);
        // Reset lands on address 11, then a clean restart from 0.
        run_frame(0, 5, 5, 3, 1, 1, -1, -1, 7);
        run_frame(0, 5, 5, 3, 1, 1, -1, -1, -1);

        run_frame(1, 5, 5, 3, 2, 1, -1, -1, -1);
        run_frame(2, 5, 5, 3, 1, 2, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
